// File: rtl/systolic_arbiter.sv
// Round-robin front end sharing one 4x4 matrix multiplier between two requesters.
// One job in flight; a job with no result within TIMEOUT wait cycles returns zero with o_resTimeout set.
module systolic_arbiter #(
    parameter int unsigned TIMEOUT = 31
) (
    input  logic         i_clk,
    input  logic         i_arst,
    input  logic [1:0]   i_reqValid,
    output logic [1:0]   o_reqReady,
    input  logic [255:0] i_reqA,
    input  logic [255:0] i_reqB,
    output logic         o_mulValidInput,
    output logic [127:0] o_mulA,
    output logic [127:0] o_mulB,
    input  logic         i_mulValidResult,
    input  logic [255:0] i_mulC,
    output logic [1:0]   o_resValid,
    input  logic [1:0]   i_resReady,
    output logic [255:0] o_resC,
    output logic         o_resTimeout,
    output logic         o_busy
);
    localparam int unsigned MAT_W = 128;
    localparam int unsigned RES_W = 256;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MAT_W-1:0]   mul_a_q, mul_a_d;
    logic [MAT_W-1:0]   mul_b_q, mul_b_d;
    logic [RES_W-1:0]   res_c_q, res_c_d;
    logic               res_to_q, res_to_d;
    logic               mul_valid_q, mul_valid_d;
    logic [1:0]         res_valid_q, res_valid_d;
    logic               busy_q, busy_d;

    logic               winner_c;
    logic [1:0]         grant_c;

    // Lone requester wins outright; contention is resolved by the pointer.
    always_comb begin
        winner_c = ptr_q;
        if (i_reqValid == 2'b01) begin
            winner_c = 1'b0;
        end else if (i_reqValid == 2'b10) begin
            winner_c = 1'b1;
        end
        grant_c = 2'b00;
        if (state_q == ST_IDLE && !i_arst && i_reqValid != 2'b00) begin
            grant_c = winner_c ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        res_c_d     = res_c_q;
        res_to_d    = res_to_q;
        mul_valid_d = 1'b0;
        res_valid_d = 2'b00;
        busy_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_c != 2'b00) begin
                    mul_a_d = winner_c ? i_reqA[255:128] : i_reqA[127:0];
                    mul_b_d = winner_c ? i_reqB[255:128] : i_reqB[127:0];
                    owner_d = winner_c;
                    ptr_d   = ~winner_c;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_W'(1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the timeout cycle still wins.
                if (i_mulValidResult) begin
                    res_c_d  = i_mulC;
                    res_to_d = 1'b0;
                    state_d  = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    res_c_d  = '0;
                    res_to_d = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (i_resReady[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        mul_valid_d = (state_d == ST_ISSUE);
        busy_d      = (state_d != ST_IDLE);
        if (state_d == ST_RESP) begin
            res_valid_d = owner_d ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 1'b0;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            res_c_q     <= '0;
            res_to_q    <= 1'b0;
            mul_valid_q <= 1'b0;
            res_valid_q <= 2'b00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            res_c_q     <= res_c_d;
            res_to_q    <= res_to_d;
            mul_valid_q <= mul_valid_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign o_reqReady      = grant_c;
    assign o_mulValidInput = mul_valid_q;
    assign o_mulA          = mul_a_q;
    assign o_mulB          = mul_b_q;
    assign o_resValid      = res_valid_q;
    assign o_resC          = res_c_q;
    assign o_resTimeout    = res_to_q;
    assign o_busy          = busy_q;

endmodule

// File: tb/tb_systolic_arbiter.sv
// Randomised job-level bench for systolic_arbiter: the bench plays both requesters and the
// multiplier, and predicts grants, latency and results from the round-robin and timeout rules.
module tb_systolic_arbiter;
    localparam int unsigned TO = 31;

    logic         i_clk = 1'b0;
    logic         i_arst;
    logic [1:0]   i_reqValid;
    logic [1:0]   o_reqReady;
    logic [255:0] i_reqA;
    logic [255:0] i_reqB;
    logic         o_mulValidInput;
    logic [127:0] o_mulA;
    logic [127:0] o_mulB;
    logic         i_mulValidResult;
    logic [255:0] i_mulC;
    logic [1:0]   o_resValid;
    logic [1:0]   i_resReady;
    logic [255:0] o_resC;
    logic         o_resTimeout;
    logic         o_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_ptr = 0;
    logic [127:0] pend_a [2];
    logic [127:0] pend_b [2];

    systolic_arbiter #(.TIMEOUT(TO)) dut (
        .i_clk            (i_clk),
        .i_arst           (i_arst),
        .i_reqValid       (i_reqValid),
        .o_reqReady       (o_reqReady),
        .i_reqA           (i_reqA),
        .i_reqB           (i_reqB),
        .o_mulValidInput  (o_mulValidInput),
        .o_mulA           (o_mulA),
        .o_mulB           (o_mulB),
        .i_mulValidResult (i_mulValidResult),
        .i_mulC           (i_mulC),
        .o_resValid       (o_resValid),
        .i_resReady       (i_resReady),
        .o_resC           (o_resC),
        .o_resTimeout     (o_resTimeout),
        .o_busy           (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand_mat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] junk();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Plain 4x4 product, each element truncated to 16 bits.
    function automatic logic [255:0] matmul(input logic [127:0] a, input logic [127:0] b);
        logic [255:0] c;
        int unsigned  s;
        c = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++) begin
                    s += int'(a[(i*4+k)*8 +: 8]) * int'(b[(k*4+j)*8 +: 8]);
                end
                c[(i*4+j)*16 +: 16] = s[15:0];
            end
        end
        return c;
    endfunction

    task automatic drive_req(input logic [1:0] mask);
        i_reqValid = mask;
        i_reqA     = {pend_a[1], pend_a[0]};
        i_reqB     = {pend_b[1], pend_b[0]};
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
    // lat: wait cycle of the multiplier result (outside 1..TO means it never arrives in time).
    task automatic run_job(input logic [1:0] mask, input int lat, input int hold,
                           input int rst_at, input bit stray);
        int           w, arrive, exp_arrive;
        bit           to, bad_ready, bad_mul, bad_busy, bad_stab;
        logic [127:0] job_a, job_b;
        logic [255:0] exp_c, snap_c;
        logic [1:0]   snap_v, own;
        logic         snap_t;
        bad_ready = 0; bad_mul = 0; bad_busy = 0; bad_stab = 0;

        drive_req(mask);
        w   = (mask == 2'b01) ? 0 : (mask == 2'b10) ? 1 : exp_ptr;
        own = (w == 1) ? 2'b10 : 2'b01;
        #1;
        chk("grant", 256'(o_reqReady), 256'(own));
        job_a      = pend_a[w];
        job_b      = pend_b[w];
        exp_c      = matmul(job_a, job_b);
        exp_ptr    = 1 - w;
        to         = (lat < 1) || (lat > int'(TO));
        exp_arrive = to ? int'(TO) + 2 : lat + 2;
        pend_a[w]  = rand_mat();
        pend_b[w]  = rand_mat();
        arrive     = 0;

        for (int c = 1; c <= int'(TO) + 8; c++) begin
            @(negedge i_clk);
            if (c == 1) begin
                drive_req(mask);
                chk("mul_pulse", 256'(o_mulValidInput), 256'(1));
                chk("mulA", 256'(o_mulA), 256'(job_a));
                chk("mulB", 256'(o_mulB), 256'(job_b));
            end else if (o_mulValidInput !== 1'b0) begin
                bad_mul = 1;
            end
            if (rst_at > 0 && c == rst_at + 1) begin
                i_arst = 1'b1;
                @(negedge i_clk);
                i_arst     = 1'b0;
                i_reqValid = 2'b00;
                chk("rst_busy", 256'(o_busy), 256'(0));
                chk("rst_resValid", 256'(o_resValid), 256'(0));
                for (int s = 0; s < 4; s++) begin
                    i_mulValidResult = (s == 1);
                    i_mulC           = junk();
                    @(negedge i_clk);
                    if (o_resValid !== 2'b00 || o_busy !== 1'b0) bad_stab = 1;
                end
                i_mulValidResult = 1'b0;
                chk("rst_quiet", 256'(bad_stab), 256'(0));
                exp_ptr = 0;
                return;
            end
            if (o_resValid !== 2'b00) begin
                arrive = c;
                break;
            end
            if (o_busy !== 1'b1) bad_busy = 1;
            #1;
            if (o_reqReady !== 2'b00) bad_ready = 1;
            i_mulValidResult = (!to && c == lat + 1) || (stray && c == 1);
            i_mulC = (!to && c == lat + 1) ? matmul(o_mulA, o_mulB) : junk();
        end
        i_mulValidResult = 1'b0;

        chk("latency", 256'(arrive), 256'(exp_arrive));
        chk("resValid", 256'(o_resValid), 256'(own));
        chk("resC", o_resC, to ? 256'(0) : exp_c);
        chk("resTimeout", 256'(o_resTimeout), 256'(to));

        // Stall the owner while the other requester offers a spurious accept.
        snap_v     = o_resValid;
        snap_c     = o_resC;
        snap_t     = o_resTimeout;
        i_resReady = ~own;
        for (int h = 0; h < hold; h++) begin
            i_mulValidResult = stray;
            i_mulC           = junk();
            #1;
            if (o_reqReady !== 2'b00) bad_ready = 1;
            @(negedge i_clk);
            if (o_resValid !== snap_v || o_resC !== snap_c || o_resTimeout !== snap_t) bad_stab = 1;
            if (o_mulValidInput !== 1'b0) bad_mul = 1;
        end
        i_mulValidResult = 1'b0;
        #1;
        if (o_reqReady !== 2'b00) bad_ready = 1;
        i_resReady = own;
        @(negedge i_clk);
        i_resReady = 2'b00;
        chk("done_resValid", 256'(o_resValid), 256'(0));
        chk("done_busy", 256'(o_busy), 256'(0));
        chk("no_extra_mul", 256'(bad_mul), 256'(0));
        chk("ready_quiet", 256'(bad_ready), 256'(0));
        chk("busy_held", 256'(bad_busy), 256'(0));
        chk("resp_stable", 256'(bad_stab), 256'(0));
    endtask

    initial begin
        logic [127:0] ident, ramp;
        logic [255:0] ramp16;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                ident[(i*4+j)*8 +: 8]   = (i == j) ? 8'd1 : 8'd0;
                ramp[(i*4+j)*8 +: 8]    = 8'(i*4+j);
                ramp16[(i*4+j)*16 +: 16] = 16'(i*4+j);
            end
        end
        pend_a[0] = rand_mat(); pend_b[0] = rand_mat();
        pend_a[1] = rand_mat(); pend_b[1] = rand_mat();
        i_arst = 1'b1;
        drive_req(2'b11);
        i_mulValidResult = 1'b0;
        i_mulC           = '0;
        i_resReady       = 2'b00;

        repeat (3) @(negedge i_clk);
        #1;
        chk("rst_reqReady", 256'(o_reqReady), 256'(0));
        chk("rst_mulValid", 256'(o_mulValidInput), 256'(0));
        chk("rst_resValid0", 256'(o_resValid), 256'(0));
        chk("rst_resTimeout", 256'(o_resTimeout), 256'(0));
        chk("rst_busy0", 256'(o_busy), 256'(0));
        chk("rst_mulA", 256'(o_mulA), 256'(0));
        chk("rst_mulB", 256'(o_mulB), 256'(0));
        chk("rst_resC", o_resC, 256'(0));
        i_reqValid = 2'b00;
        i_arst     = 1'b0;
        @(negedge i_clk);

        // Identity times ramp from requester 1.
        pend_a[1] = ident;
        pend_b[1] = ramp;
        run_job(2'b10, 12, 0, 0, 0);
        chk("ident_resC", o_resC, ramp16);

        // Both requesting continuously: strict alternation.
        for (int n = 0; n < 4; n++) run_job(2'b11, int'($urandom_range(1, 10)), 0, 0, 0);

        run_job(2'b01, 5, 20, 0, 1);
        run_job(2'b11, 0, 1, 0, 0);
        run_job(2'b11, 7, 0, 0, 0);
        run_job(2'b11, int'(TO), 0, 0, 0);
        run_job(2'b01, 12, 0, 3, 0);
        run_job(2'b11, 6, 0, 0, 0);

        for (int n = 0; n < 30; n++) begin
            run_job(2'($urandom_range(1, 3)), int'($urandom_range(1, 40)),
                    int'($urandom_range(0, 3)), 0, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
